// File: rtl/grant_session_ctrl.sv
// rtl/grant_session_ctrl.sv - Fixed-length ownership sessions driven by a one-hot arbiter grant.
module grant_session_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int CNT_W       = 8,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       grant,
    input  logic                     viol_clr,
    output logic                     owner_valid,
    output logic [ID_W-1:0]          owner_id,
    output logic [NUM_REQ-1:0]       done,
    output logic                     abort,
    output logic                     busy,
    output logic                     violation,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);

    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWN       = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   cnt [NUM_REQ];

    logic [ID_W:0]      pop;
    logic [ID_W-1:0]    hot_id;
    logic               multi_hot;
    logic               one_hot;
    logic               owner_bit;

    // Population count and index of the highest set bit; the index is only used when one-hot.
    always_comb begin
        pop    = '0;
        hot_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop = pop + (ID_W+1)'(grant_q[i]);
            if (grant_q[i]) begin
                hot_id = ID_W'(i);
            end
        end
        multi_hot = (pop > (ID_W+1)'(1));
        one_hot   = (pop == (ID_W+1)'(1));
        owner_bit = grant_q[owner_id];
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_flat
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_q     <= '0;
            timer       <= '0;
            owner_id    <= '0;
            owner_valid <= 1'b0;
            done        <= '0;
            abort       <= 1'b0;
            busy        <= 1'b0;
            violation   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            grant_q <= grant;
            done    <= '0;
            abort   <= 1'b0;

            // Set has priority over clear so a persisting fault is never lost.
            if (multi_hot) begin
                violation <= 1'b1;
            end else if (viol_clr) begin
                violation <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state       <= OWN;
                        owner_id    <= hot_id;
                        owner_valid <= 1'b1;
                        busy        <= 1'b1;
                        timer       <= TMR_INIT;
                        if (cnt[hot_id] != '1) begin
                            cnt[hot_id] <= cnt[hot_id] + 1'b1;
                        end
                    end
                end
                OWN: begin
                    if (!owner_bit) begin
                        state       <= IDLE;
                        owner_valid <= 1'b0;
                        busy        <= 1'b0;
                        abort       <= 1'b1;
                    end else if (timer == '0) begin
                        state           <= WAIT_DROP;
                        owner_valid     <= 1'b0;
                        done[owner_id]  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_DROP: begin
                    // Hold off new owners until the finished owner releases its grant.
                    if (!owner_bit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    owner_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_session_ctrl.sv
// tb/tb_grant_session_ctrl.sv - Self-checking bench for grant_session_ctrl.
module tb_grant_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  grant, grant2;
    logic        viol_clr, viol_clr2;
    logic        owner_valid, owner_valid2;
    logic [1:0]  owner_id, owner_id2;
    logic [3:0]  done, done2;
    logic        abort, abort2;
    logic        busy, busy2;
    logic        violation, violation2;
    logic [31:0] grant_cnt;
    logic [7:0]  grant_cnt2;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] grant;
        logic       clr;
        logic       ov;
        logic [1:0] id;
        logic [3:0] done;
        logic       abort;
        logic       busy;
        logic       viol;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    grant_session_ctrl dut (
        .clk(clk), .rst_n(rst_n), .grant(grant), .viol_clr(viol_clr),
        .owner_valid(owner_valid), .owner_id(owner_id), .done(done), .abort(abort),
        .busy(busy), .violation(violation), .grant_cnt(grant_cnt)
    );

    grant_session_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .grant(grant2), .viol_clr(viol_clr2),
        .owner_valid(owner_valid2), .owner_id(owner_id2), .done(done2), .abort(abort2),
        .busy(busy2), .violation(violation2), .grant_cnt(grant_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] g, input logic c, input logic ov,
                                input logic [1:0] id, input logic [3:0] d,
                                input logic ab, input logic b, input logic v);
        vec_t r;
        r.grant = g; r.clr = c; r.ov = ov; r.id = id;
        r.done = d; r.abort = ab; r.busy = b; r.viol = v;
        return r;
    endfunction

    initial begin
        vec_t e;
        logic got;

        rst_n = 1'b0; grant = '0; viol_clr = 1'b0; grant2 = '0; viol_clr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {owner_valid, owner_id, done, abort, busy, violation}, '0);
        check("reset_cnt", grant_cnt, '0);
        check("reset_cnt_sat", {24'd0, grant_cnt2}, '0);
        @(negedge clk) rst_n = 1'b1;

        // Single session for requester 2.
        tbl.push_back(mk(4'b0100,0, 0,2'd0,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0100,0, 1,2'd2,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0100,0, 1,2'd2,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0100,0, 1,2'd2,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0100,0, 0,2'd2,4'b0100,0,1,0));
        tbl.push_back(mk(4'b0100,0, 0,2'd2,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd2,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd2,4'b0000,0,0,0));
        // Back-to-back: owner 1, minimum gap, then owner 0.
        tbl.push_back(mk(4'b0010,0, 0,2'd2,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0010,0, 1,2'd1,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0010,0, 1,2'd1,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0010,0, 1,2'd1,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0010,0, 0,2'd1,4'b0010,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd1,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0001,0, 0,2'd1,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0001,0, 1,2'd0,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0001,0, 1,2'd0,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0001,0, 1,2'd0,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0001,0, 0,2'd0,4'b0001,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd0,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd0,4'b0000,0,0,0));
        // Early revoke of requester 3.
        tbl.push_back(mk(4'b1000,0, 0,2'd0,4'b0000,0,0,0));
        tbl.push_back(mk(4'b1000,0, 1,2'd3,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0000,0, 1,2'd3,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd3,4'b0000,1,0,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd3,4'b0000,0,0,0));
        // Multi-hot in IDLE, clear, then set-wins-over-clear.
        tbl.push_back(mk(4'b0110,0, 0,2'd3,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0110,0, 0,2'd3,4'b0000,0,0,1));
        tbl.push_back(mk(4'b0000,0, 0,2'd3,4'b0000,0,0,1));
        tbl.push_back(mk(4'b0000,1, 0,2'd3,4'b0000,0,0,0));
        tbl.push_back(mk(4'b1111,1, 0,2'd3,4'b0000,0,0,0));
        tbl.push_back(mk(4'b1111,1, 0,2'd3,4'b0000,0,0,1));
        tbl.push_back(mk(4'b0000,1, 0,2'd3,4'b0000,0,0,1));
        tbl.push_back(mk(4'b0000,1, 0,2'd3,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0000,0, 0,2'd3,4'b0000,0,0,0));
        // Extra grant bit during a session: flag only, session completes.
        tbl.push_back(mk(4'b0001,0, 0,2'd3,4'b0000,0,0,0));
        tbl.push_back(mk(4'b0011,0, 1,2'd0,4'b0000,0,1,0));
        tbl.push_back(mk(4'b0011,0, 1,2'd0,4'b0000,0,1,1));
        tbl.push_back(mk(4'b0001,0, 1,2'd0,4'b0000,0,1,1));
        tbl.push_back(mk(4'b0001,0, 0,2'd0,4'b0001,0,1,1));
        tbl.push_back(mk(4'b0000,0, 0,2'd0,4'b0000,0,1,1));
        tbl.push_back(mk(4'b0000,1, 0,2'd0,4'b0000,0,0,0));

        foreach (tbl[k]) begin
            @(negedge clk);
            grant    = tbl[k].grant;
            viol_clr = tbl[k].clr;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("step%0d", k + 1),
                  {22'd0, owner_valid, owner_id, done, abort, busy, violation},
                  {22'd0, e.ov, e.id, e.done, e.abort, e.busy, e.viol});
        end
        @(negedge clk) viol_clr = 1'b0;
        check("counters", grant_cnt, 32'h01010102);

        // Saturation with 2-bit counters.
        for (int s = 0; s < 5; s++) begin
            @(negedge clk) grant2 = 4'b0001;
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                @(posedge clk);
                #1;
                if (done2 == 4'b0001) got = 1'b1;
            end
            check($sformatf("sat_done%0d", s), {31'd0, got}, 32'd1);
            check($sformatf("sat_cnt%0d", s), {30'd0, grant_cnt2[1:0]}, (s < 2) ? s + 1 : 3);
            @(negedge clk) grant2 = 4'b0000;
            repeat (3) @(posedge clk);
        end
        check("sat_others", {26'd0, grant_cnt2[7:2]}, '0);

        // Reset in the middle of a session.
        @(negedge clk) grant = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_ov", {31'd0, owner_valid}, 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("rst_outs", {owner_valid, owner_id, done, abort, busy, violation}, '0);
        check("rst_cnt", grant_cnt, '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", c), {done, abort, owner_valid}, '0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_lat", {31'd0, owner_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_own", {29'd0, owner_valid, owner_id}, {29'd0, 1'b1, 2'd2});
        check("post_rst_cnt", grant_cnt, 32'h00010000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/grant_session_ctrl.md
Name: grant_session_ctrl

Overview:
- Downstream consumer of the 4-way mutex arbiter's one-hot grant outputs (Y3..Y0).
- Registers the grant vector and runs a fixed-length ownership session for the granted requester. Pulses a per-requester done, then waits for the grant to drop before accepting the next owner.
- Keeps saturating per-requester grant counters and a sticky mutual-exclusion violation flag used to check the arbiter in-system.

Parameters:
- NUM_REQ, 4, number of requesters; width of the grant vector; must be >= 2.
- HOLD_CYCLES, 3, cycles owner_valid stays high per session; must be >= 1.
- CNT_W, 8, width of each per-requester grant counter.
- ID_W, 2, width of owner_id; equals clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- grant  in  NUM_REQ  arbiter grant vector (bit i = Yi); expected one-hot or zero.
- viol_clr  in  1  synchronous clear of the sticky violation flag.
- owner_valid  out  1  a session is active.
- owner_id  out  ID_W  index of the current owner; holds its last value when owner_valid=0.
- done  out  NUM_REQ  one-cycle pulse on bit i when requester i's session completes normally.
- abort  out  1  one-cycle pulse when the owner's grant is revoked before session end.
- busy  out  1  FSM not in IDLE.
- violation  out  1  sticky; set when the registered grant vector has more than one bit high.
- grant_cnt  out  NUM_REQ*CNT_W  flattened counters; slice i = [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, grant_q=0, timer=0, owner_id=0, owner_valid=0, done=0, abort=0, busy=0, violation=0, all counters=0. Reset mid-session discards the session with no done or abort pulse.
- grant_q: grant is registered every rising edge. All decisions use grant_q, so grant has 1 cycle of input latency. Multi-hot means popcount(grant_q) > 1.
- violation: set on any cycle grant_q is multi-hot, in every state. viol_clr clears it. If set and clear happen on the same cycle, set wins.
- IDLE:
  - If grant_q is exactly one-hot with bit i: go to OWN, set owner_id=i, owner_valid=1, timer=HOLD_CYCLES-1, and increment grant_cnt[i].
  - If grant_q is zero or multi-hot: stay in IDLE with no session and no count.
- OWN:
  - If grant_q[owner_id]=0: pulse abort for 1 cycle, set owner_valid=0, go to IDLE. No done pulse.
  - Otherwise, if timer==0: set owner_valid=0, pulse done[owner_id] for 1 cycle, go to WAIT_DROP.
  - Otherwise: decrement timer.
  - Extra grant bits appearing alongside the owner bit only set violation; the session continues.
- WAIT_DROP: stay until grant_q[owner_id]==0, then go to IDLE. A grant to another index seen here is ignored. It is accepted from IDLE on the next cycle if still present.
- Latency: grant one-hot and stable before edge N, so grant_q is set at N and owner_valid rises at N+1. owner_valid is high for exactly HOLD_CYCLES cycles, and done is high the next cycle.
- Minimum gap between sessions of different requesters: one WAIT_DROP cycle plus one IDLE cycle.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Outputs are registered. done and abort are never high in the same cycle. done is zero or one-hot.

Test Plan:
- Defaults. Drive grant=4'b0100 from cycle 0 and hold. Required: owner_valid high for 3 cycles starting 2 edges after the grant, owner_id=2, then done=4'b0100 for 1 cycle, busy until grant drops, grant_cnt[2]=1, violation=0.
- Back-to-back. grant=0010 until done, then 0000 for 1 cycle, then 0001. Required: sessions run for owner 1 and then owner 0, each with a done pulse. Counters [1]=1 and [0]=1; others 0.
- Early revoke. grant=1000, dropped to 0000 after owner_valid has been high 1 cycle. Required: one abort pulse, no done, owner_valid low, return to IDLE, grant_cnt[3]=1.
- Multi-hot. Drive grant=1111 (or 0110) in IDLE. Required: violation=1, no session, counters unchanged. Then assert viol_clr with grant=0. Required: violation returns to 0. With viol_clr held during a multi-hot grant, violation stays 1.
- Saturation. CNT_W=2, 5 complete sessions for requester 0. Required: grant_cnt[0] counts 1,2,3,3,3.
- Reset mid-session. Pull rst_n low while owner_valid=1. Required: all outputs 0 immediately, no done or abort pulse. After release, a fresh grant starts a new session normally.
